// File: rtl/gate_response_misr.sv
// gate_response_misr: compacts 10-bit gate-model response words into a 16-bit
// multiple-input signature register over a programmed number of patterns, then
// compares the final signature against a golden value.
module gate_response_misr #(
  parameter int          RESP_W = 10,
  parameter int          SIG_W  = 16,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIG_W-1:0]  pat_count,
  input  logic [SIG_W-1:0]  golden,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [SIG_W-1:0]  accepted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [SIG_W-1:0]   pat_count_r;
  logic [SIG_W-1:0]   golden_r;
  logic               transfer_s;
  logic               last_s;
  logic [SIG_W-1:0]   next_sig_s;

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial, then XOR in the zero-extended response word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [RESP_W-1:0] word);
    logic [SIG_W-1:0] shifted;
    shifted = {sig[SIG_W-2:0], 1'b0};
    if (sig[SIG_W-1]) begin
      shifted = shifted ^ POLY[SIG_W-1:0];
    end else begin
      shifted = shifted;
    end
    return shifted ^ {{(SIG_W-RESP_W){1'b0}}, word};
  endfunction

  // Handshake decode and next-signature computation for the current cycle.
  always_comb begin
    transfer_s = resp_valid & resp_ready & (state_r == RUN);
    next_sig_s = misr_step(signature, resp);
    last_s     = ((accepted + {{(SIG_W-1){1'b0}}, 1'b1}) == pat_count_r);
  end

  // Run control FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pat_count_r <= {SIG_W{1'b0}};
      golden_r    <= {SIG_W{1'b0}};
      resp_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      signature   <= SEED[SIG_W-1:0];
      accepted    <= {SIG_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            pat_count_r <= pat_count;
            golden_r    <= golden;
            signature   <= SEED[SIG_W-1:0];
            accepted    <= {SIG_W{1'b0}};
            if (pat_count == {SIG_W{1'b0}}) begin
              // Empty run: the seed itself is the final signature.
              state_r    <= DONE;
              done       <= 1'b1;
              pass       <= (SEED[SIG_W-1:0] == golden);
              busy       <= 1'b0;
              resp_ready <= 1'b0;
            end else begin
              state_r    <= RUN;
              done       <= 1'b0;
              pass       <= 1'b0;
              busy       <= 1'b1;
              resp_ready <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (transfer_s) begin
            signature <= next_sig_s;
            accepted  <= accepted + {{(SIG_W-1){1'b0}}, 1'b1};
            if (last_s) begin
              // Pass is judged on the signature that includes this last word.
              state_r    <= DONE;
              done       <= 1'b1;
              pass       <= (next_sig_s == golden_r);
              busy       <= 1'b0;
              resp_ready <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r    <= IDLE;
          resp_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
          signature  <= SEED[SIG_W-1:0];
          accepted   <= {SIG_W{1'b0}};
        end
      endcase
    end
  end

endmodule
